// File: rtl/flash_audio_streamer_pkg.sv
// flash_player_pkg: fetch states, buffer slot metadata and address stepping shared by the streamer.
package flash_player_pkg;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;
    typedef struct packed {logic v; logic fwd; logic last;} slot_meta_t;
    typedef struct packed {logic [31:0] next; logic exhausted;} step_t;
    function automatic int spw(int data_w, int sample_w);
        return data_w / sample_w;
    endfunction
    // Wraps inside [lo, hi] when looping, otherwise holds the pointer and flags the window as used up.
    function automatic step_t step_addr(logic [31:0] ptr, logic dir, logic loop, logic [31:0] lo, logic [31:0] hi);
        step_t s;
        logic at_end;
        at_end = dir ? (ptr == hi) : (ptr == lo);
        s.next = at_end ? (loop ? (dir ? lo : hi) : ptr) : (dir ? ptr + 32'd1 : ptr - 32'd1);
        s.exhausted = at_end && !loop;
        return s;
    endfunction
endpackage

// File: rtl/flash_audio_streamer_if.sv
// flash_audio_streamer_if: Avalon-MM read port between the streamer and the flash controller.
interface flash_audio_streamer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic read;
    logic waitrequest;
    logic [DATA_W-1:0] readdata;
    logic readdatavalid;
    modport master (output address, read, input waitrequest, readdata, readdatavalid);
    modport slave (input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_audio_streamer_fetcher.sv
// flash_word_fetcher: single-outstanding Avalon read FSM filling a two-word prefetch buffer.
module flash_word_fetcher
    import flash_player_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(23'h7FFFF)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic direction,
    input  logic loop_en,
    input  logic restart,
    input  logic done,
    input  logic pop,
    flash_audio_streamer_if.master mem,
    output logic cur_valid,
    output logic cur_fwd,
    output logic cur_last,
    output logic [DATA_W-1:0] cur_data
);
    fetch_state_t st_q, st_d;
    logic read_q, read_d, exh_q, exh_d, disc_q, disc_d;
    logic pend_fwd_q, pend_fwd_d, pend_last_q, pend_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ptr_q, ptr_d;
    slot_meta_t cur_q, cur_d, nxt_q, nxt_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
    step_t stp;
    always_comb begin
        st_d = st_q;
        read_d = read_q;
        addr_d = addr_q;
        ptr_d = ptr_q;
        exh_d = exh_q;
        disc_d = disc_q;
        pend_fwd_d = pend_fwd_q;
        pend_last_d = pend_last_q;
        stp = step_addr(32'(ptr_q), direction, loop_en, 32'(START_ADDR), 32'(END_ADDR));
        cur_d = pop ? nxt_q : cur_q;
        cur_data_d = pop ? nxt_data_q : cur_data_q;
        nxt_d = pop ? '0 : nxt_q;
        nxt_data_d = nxt_data_q;
        case (st_q)
            F_IDLE: if ((!cur_q.v || !nxt_q.v) && !done && !exh_q && !restart) begin
                st_d = F_REQ;
                read_d = 1'b1;
                addr_d = ptr_q;
            end
            F_REQ: if (!mem.waitrequest) begin
                st_d = F_WAIT;
                read_d = 1'b0;
                if (!disc_q && !restart) begin
                    ptr_d = ADDR_W'(stp.next);
                    exh_d = stp.exhausted;
                    pend_fwd_d = direction;
                    pend_last_d = stp.exhausted;
                end
            end
            F_WAIT: if (mem.readdatavalid) begin
                st_d = F_IDLE;
                disc_d = 1'b0;
                if (!disc_q && !restart) begin
                    if (!cur_d.v) begin
                        cur_d = '{v: 1'b1, fwd: pend_fwd_q, last: pend_last_q};
                        cur_data_d = mem.readdata;
                    end else begin
                        nxt_d = '{v: 1'b1, fwd: pend_fwd_q, last: pend_last_q};
                        nxt_data_d = mem.readdata;
                    end
                end
            end
            default: st_d = F_IDLE;
        endcase
        // A read already on the bus must still finish; its data is dropped via disc.
        if (restart) begin
            cur_d = '0;
            nxt_d = '0;
            ptr_d = direction ? START_ADDR : END_ADDR;
            exh_d = 1'b0;
            disc_d = (st_q == F_REQ) || (st_q == F_WAIT && !mem.readdatavalid);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q <= F_IDLE;
            read_q <= 1'b0;
            addr_q <= START_ADDR;
            ptr_q <= START_ADDR;
            exh_q <= 1'b0;
            disc_q <= 1'b0;
            pend_fwd_q <= 1'b0;
            pend_last_q <= 1'b0;
            cur_q <= '0;
            nxt_q <= '0;
            cur_data_q <= '0;
            nxt_data_q <= '0;
        end else begin
            st_q <= st_d;
            read_q <= read_d;
            addr_q <= addr_d;
            ptr_q <= ptr_d;
            exh_q <= exh_d;
            disc_q <= disc_d;
            pend_fwd_q <= pend_fwd_d;
            pend_last_q <= pend_last_d;
            cur_q <= cur_d;
            nxt_q <= nxt_d;
            cur_data_q <= cur_data_d;
            nxt_data_q <= nxt_data_d;
        end
    end
    assign mem.read = read_q;
    assign mem.address = addr_q;
    assign cur_valid = cur_q.v;
    assign cur_fwd = cur_q.fwd;
    assign cur_last = cur_q.last;
    assign cur_data = cur_data_q;
endmodule

// File: rtl/flash_audio_streamer.sv
// flash_audio_streamer: plays flash words as SAMPLE_W-bit samples, one per trigger,
// with prefetch, loop/one-shot and forward/reverse order.
module flash_audio_streamer
    import flash_player_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(23'h7FFFF)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    input  logic play_enable,
    input  logic direction,
    input  logic loop_en,
    input  logic restart,
    flash_audio_streamer_if.master mem,
    output logic [SAMPLE_W-1:0] audio_sample,
    output logic sample_valid,
    output logic done,
    output logic underrun
);
    localparam int SPW = spw(DATA_W, SAMPLE_W);
    localparam int IW = SPW > 1 ? $clog2(SPW) : 1;
    logic cur_valid, cur_fwd, cur_last, act, serve, pop;
    logic [DATA_W-1:0] cur_data;
    logic [IW-1:0] idx_q, idx_d, pos;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic valid_q, valid_d, done_q, done_d, under_q, under_d;
    flash_word_fetcher #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR)
    ) u_fetch (
        .clk(clk), .reset_n(reset_n), .direction(direction), .loop_en(loop_en),
        .restart(restart), .done(done_q), .pop(pop), .mem(mem),
        .cur_valid(cur_valid), .cur_fwd(cur_fwd), .cur_last(cur_last), .cur_data(cur_data)
    );
    // idx always counts up; reverse words read it back from the top sample down.
    always_comb begin
        act = trigger && play_enable && !done_q && !restart;
        serve = act && cur_valid;
        pop = serve && (idx_q == IW'(SPW - 1));
        pos = cur_fwd ? idx_q : IW'(SPW - 1) - idx_q;
        idx_d = restart ? '0 : serve ? (pop ? '0 : idx_q + 1'b1) : idx_q;
        sample_d = serve ? cur_data[pos*SAMPLE_W +: SAMPLE_W] : sample_q;
        valid_d = serve;
        done_d = restart ? 1'b0 : done_q || (pop && cur_last);
        under_d = restart ? 1'b0 : under_q || (act && !cur_valid);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q <= '0;
            sample_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            sample_q <= sample_d;
            valid_q <= valid_d;
            done_q <= done_d;
            under_q <= under_d;
        end
    end
    assign audio_sample = sample_q;
    assign sample_valid = valid_q;
    assign done = done_q;
    assign underrun = under_q;
endmodule

// File: tb/tb_flash_audio_streamer.sv
// tb_flash_audio_streamer: directed vectors against a two-word window (0..1) behind a
// scriptable Avalon slave with programmable waitrequest and read latency.
module tb_flash_audio_streamer;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n, trigger, play_enable, direction, loop_en, restart;
    logic [7:0] audio_sample;
    logic sample_valid, done, underrun;
    flash_audio_streamer_if #(.ADDR_W(23), .DATA_W(32)) bus ();
    flash_audio_streamer #(
        .DATA_W(32), .SAMPLE_W(8), .ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .trigger(trigger), .play_enable(play_enable),
        .direction(direction), .loop_en(loop_en), .restart(restart), .mem(bus),
        .audio_sample(audio_sample), .sample_valid(sample_valid), .done(done), .underrun(underrun)
    );

    logic [31:0] mem_words [2];
    int ws_left, lat, pc;
    bit pend;
    logic [22:0] pa;
    logic [22:0] acc_log [$];
    int total, bad;

    // Slave: decides waitrequest on the falling edge; an accepted read returns lat cycles later.
    always @(negedge clk) begin
        bus.readdatavalid = 1'b0;
        if (pend) begin
            if (pc == 0) begin
                bus.readdatavalid = 1'b1;
                bus.readdata = mem_words[pa[0]];
                pend = 1'b0;
            end else pc--;
        end
        if (bus.read && ws_left > 0) begin
            bus.waitrequest = 1'b1;
            ws_left--;
        end else begin
            bus.waitrequest = 1'b0;
            if (bus.read) begin
                pend = 1'b1;
                pa = bus.address;
                pc = lat;
                acc_log.push_back(bus.address);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input bit dir, input bit lp, input int ws, input int l);
        reset_n = 1'b0;
        trigger = 1'b0;
        play_enable = 1'b1;
        restart = 1'b0;
        direction = dir;
        loop_en = lp;
        pend = 1'b0;
        ws_left = ws;
        lat = l;
        tick();
        tick();
        acc_log.delete();
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic trig;
        logic pe;
        logic ev;
        logic [7:0] es;
        logic ed;
        logic eu;
    } vec_t;
    vec_t vecs [13];
    logic [7:0] rev_exp [10];
    logic [7:0] b2b_exp [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        mem_words[0] = 32'h44332211;
        mem_words[1] = 32'h88776655;
        bus.waitrequest = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata = '0;
        vecs[0]  = '{T, T, T, 8'h11, F, F};
        vecs[1]  = '{F, T, F, 8'h11, F, F};
        vecs[2]  = '{T, F, F, 8'h11, F, F};
        vecs[3]  = '{T, T, T, 8'h22, F, F};
        vecs[4]  = '{T, T, T, 8'h33, F, F};
        vecs[5]  = '{T, T, T, 8'h44, F, F};
        vecs[6]  = '{T, T, T, 8'h55, F, F};
        vecs[7]  = '{F, T, F, 8'h55, F, F};
        vecs[8]  = '{T, T, T, 8'h66, F, F};
        vecs[9]  = '{T, T, T, 8'h77, F, F};
        vecs[10] = '{T, T, T, 8'h88, T, F};
        vecs[11] = '{T, T, F, 8'h88, T, F};
        vecs[12] = '{F, T, F, 8'h88, T, F};
        rev_exp = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77};
        b2b_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        do_reset(T, F, 0, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_addr", bus.address, 0);
        chk("rst_sample", audio_sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);

        // Forward one-shot through the table
        idle(20);
        chk("fwd_prefetch_reads", acc_log.size(), 2);
        for (int i = 0; i < 13; i++) begin
            trigger = vecs[i].trig;
            play_enable = vecs[i].pe;
            tick();
            chk($sformatf("fwd_valid[%0d]", i), sample_valid, vecs[i].ev);
            chk($sformatf("fwd_sample[%0d]", i), audio_sample, vecs[i].es);
            chk($sformatf("fwd_done[%0d]", i), done, vecs[i].ed);
            chk($sformatf("fwd_underrun[%0d]", i), underrun, vecs[i].eu);
        end
        trigger = 1'b0;
        idle(10);
        chk("fwd_no_fetch_after_done", acc_log.size(), 2);

        // Reverse loop, pointer loaded with END_ADDR by a restart right after reset
        do_reset(F, T, 0, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        idle(20);
        for (int i = 0; i < 10; i++) begin
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            chk($sformatf("rev_valid[%0d]", i), sample_valid, 1);
            chk($sformatf("rev_sample[%0d]", i), audio_sample, rev_exp[i]);
            tick();
        end
        chk("rev_nreads", acc_log.size() >= 4, 1);
        if (acc_log.size() >= 4) begin
            chk("rev_addr0", acc_log[0], 1);
            chk("rev_addr1", acc_log[1], 0);
            chk("rev_addr2", acc_log[2], 1);
            chk("rev_addr3", acc_log[3], 0);
        end

        // waitrequest held for five cycles on the first read, trigger meets an empty buffer
        do_reset(T, F, 5, 0);
        tick();
        chk("ws_read_start", bus.read, 1);
        for (int k = 0; k < 5; k++) begin
            trigger = (k == 1);
            tick();
            chk($sformatf("ws_read_held[%0d]", k), bus.read, 1);
            chk($sformatf("ws_addr_held[%0d]", k), bus.address, 0);
            if (k == 1) begin
                chk("ws_underrun", underrun, 1);
                chk("ws_no_valid", sample_valid, 0);
            end
        end
        trigger = 1'b0;
        tick();
        chk("ws_read_drop", bus.read, 0);
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("ws_first_valid", sample_valid, 1);
        chk("ws_first_sample", audio_sample, 8'h11);
        chk("ws_underrun_sticky", underrun, 1);

        // Triggers every cycle across word boundaries, zero-latency slave
        do_reset(T, T, 0, 0);
        idle(20);
        trigger = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("b2b_valid[%0d]", i), sample_valid, 1);
            chk($sformatf("b2b_sample[%0d]", i), audio_sample, b2b_exp[i]);
        end
        trigger = 1'b0;

        // Restart while a reverse read to address 1 sits in F_WAIT
        do_reset(F, F, 0, 4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        tick();
        trigger = 1'b1;
        tick();
        chk("rs_underrun_set", underrun, 1);
        restart = 1'b1;
        direction = 1'b1;
        tick();
        restart = 1'b0;
        trigger = 1'b0;
        chk("rs_trig_same_cycle_valid", sample_valid, 0);
        chk("rs_underrun_clr", underrun, 0);
        chk("rs_done_clr", done, 0);
        idle(20);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("rs_first_valid", sample_valid, 1);
        chk("rs_first_sample", audio_sample, 8'h11);
        chk("rs_log_len", acc_log.size() >= 2, 1);
        if (acc_log.size() >= 2) begin
            chk("rs_stale_addr", acc_log[0], 1);
            chk("rs_new_addr", acc_log[1], 0);
        end

        // Reset while a read to address 1 is on the bus
        do_reset(F, F, 3, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        chk("mr_read_before", bus.read, 1);
        chk("mr_addr_before", bus.address, 1);
        reset_n = 1'b0;
        tick();
        chk("mr_read", bus.read, 0);
        chk("mr_addr", bus.address, 0);
        chk("mr_sample", audio_sample, 0);
        chk("mr_valid", sample_valid, 0);
        chk("mr_done", done, 0);
        chk("mr_underrun", underrun, 0);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
